moving_window_ctrl: RTL and testbench
=====================================

MOVING_WINDOW_CTRL -- requirements
Module: moving_window_ctrl

Interface
REQ-001 The block SHALL have parameter WIN_LEN, default 64, meaning window length in samples (legal range 2..4096; need not be a power of 2).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning sample width in bits.
REQ-003 The block SHALL define AW = $clog2(WIN_LEN) and CW = $clog2(WIN_LEN+1) as derived widths.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous window flush.
REQ-007 din  input  DATA_WIDTH  new sample.
REQ-008 din_valid  input  1  din is valid this cycle; no backpressure, one sample per cycle maximum.
REQ-009 bram_wen  output  1  write enable to the attached simple-dual-port memory.
REQ-010 bram_ren  output  1  read enable to the attached memory.
REQ-011 bram_wadd  output  AW  write address.
REQ-012 bram_radd  output  AW  read address.
REQ-013 bram_win  output  DATA_WIDTH  write data.
REQ-014 bram_wout  input  DATA_WIDTH  registered read data, valid one cycle after bram_ren; read-first on same-address read/write.
REQ-015 dout_new  output  DATA_WIDTH  sample entering the window.
REQ-016 dout_old  output  DATA_WIDTH  sample leaving the window (WIN_LEN samples older), or 0 during fill.
REQ-017 dout_valid  output  1  dout_new/dout_old/fill_cnt valid, single-cycle pulse.
REQ-018 full  output  1  window holds WIN_LEN samples.
REQ-019 fill_cnt  output  CW  number of samples currently in window (0..WIN_LEN), for normaliser use.

Function
REQ-020 The block SHALL keep one pointer ptr (AW bits) and drive bram_wadd = bram_radd = ptr combinationally.
REQ-021 bram_wen and bram_ren SHALL equal din_valid & ~clear; bram_win SHALL equal din.
REQ-022 On an accepted sample (din_valid & ~clear), ptr SHALL increment, wrapping WIN_LEN-1 -> 0.
REQ-023 The state machine SHALL have two states: FILL (fill_cnt < WIN_LEN) and RUN (fill_cnt == WIN_LEN); full = (state == RUN).
REQ-024 In FILL, each accepted sample SHALL increment fill_cnt; the WIN_LEN-th accepted sample SHALL move state to RUN; in RUN fill_cnt SHALL hold at WIN_LEN.
REQ-025 Latency SHALL be 1 cycle: accepted sample at edge t gives dout_valid=1 after edge t+1 with dout_new = that sample.
REQ-026 dout_old SHALL equal bram_wout if state was RUN when the sample was accepted, else 0 (registered flag steers a mux on bram_wout).
REQ-027 fill_cnt and full SHALL be registered and update on the same edge that dout_valid rises, so dout_valid qualifies post-update values.
REQ-028 clear SHALL take priority over din_valid: on clear, ptr <= 0, fill_cnt <= 0, state <= FILL; a sample presented with clear SHALL be dropped (no write, no dout_valid).
REQ-029 A sample accepted the cycle before clear SHALL still produce its normal output one cycle later.
REQ-030 Memory contents SHALL NOT be cleared; stale data after clear is masked by REQ-026.
REQ-031 Gaps in din_valid SHALL hold all state; dout_valid SHALL be 0 in cycles following no accepted sample.

Reset
REQ-032 While rst_n=0: ptr=0, state=FILL, fill_cnt=0, full=0, dout_valid=0, dout_new=0, dout_old=0; bram_wen/bram_ren=0.
REQ-033 Reset assertion mid-stream SHALL abort immediately; first sample after release SHALL be treated as sample 1 of a fresh window.

Verification
REQ-034 WIN_LEN=4: samples 1..6 back-to-back -> dout_old = 0,0,0,0,1,2; dout_new = 1..6; full rises with output of sample 4; fill_cnt 1,2,3,4,4,4.
REQ-035 WIN_LEN=4: ten samples with din_valid idle every other cycle -> identical dout sequence as contiguous case; dout_valid only after accepted samples.
REQ-036 WIN_LEN=5 (non-power-of-2): 12 samples -> ptr wraps 4->0; dout_old of sample k = sample k-5 for k>=6.
REQ-037 WIN_LEN=4: 6 samples, clear with din_valid=1 (sample 7 dropped), then samples 8..9 -> fill_cnt 1,2; dout_old = 0,0; bram_wadd 0,1.
REQ-038 rst_n pulsed low asynchronously mid-cycle during RUN -> outputs zero immediately; next samples produce dout_old=0, fill_cnt restarting at 1.

Source files
------------

// File: rtl/moving_window_ctrl_if.sv
// Bus bundle for the moving-window controller: sample stream in, memory port
// out/in, and the qualified window outputs. The slave modport is the controller
// side. The master modport is the surrounding logic, which drives the samples
// and supplies the memory's registered read data.
interface moving_window_ctrl_if #(
    parameter int WIN_LEN    = 64,
    parameter int DATA_WIDTH = 16
);
    localparam int AW = $clog2(WIN_LEN);
    localparam int CW = $clog2(WIN_LEN + 1);

    logic                  clear;
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;

    logic                  bram_wen;
    logic                  bram_ren;
    logic [AW-1:0]         bram_wadd;
    logic [AW-1:0]         bram_radd;
    logic [DATA_WIDTH-1:0] bram_win;
    logic [DATA_WIDTH-1:0] bram_wout;

    logic [DATA_WIDTH-1:0] dout_new;
    logic [DATA_WIDTH-1:0] dout_old;
    logic                  dout_valid;
    logic                  full;
    logic [CW-1:0]         fill_cnt;

    modport master (
        output clear, din, din_valid, bram_wout,
        input  bram_wen, bram_ren, bram_wadd, bram_radd, bram_win,
        input  dout_new, dout_old, dout_valid, full, fill_cnt
    );

    modport slave (
        input  clear, din, din_valid, bram_wout,
        output bram_wen, bram_ren, bram_wadd, bram_radd, bram_win,
        output dout_new, dout_old, dout_valid, full, fill_cnt
    );
endinterface

// File: rtl/moving_window_ctrl.sv
// Moving-window controller. Each accepted sample is written into an external
// simple-dual-port memory used as a circular buffer of WIN_LEN entries. The
// entry being overwritten is read at the same address in the same cycle.
// Because the memory is read-first, that read returns the sample leaving the
// window. One cycle later the controller presents the new sample, the departing
// sample, and the window fill level.
module moving_window_ctrl #(
    parameter int WIN_LEN    = 64,
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    moving_window_ctrl_if.slave  bus
);
    localparam int AW = $clog2(WIN_LEN);
    localparam int CW = $clog2(WIN_LEN + 1);

    localparam logic [AW-1:0] PTR_LAST  = AW'(WIN_LEN - 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(WIN_LEN - 1);
    localparam logic [CW-1:0] FILL_MAX  = CW'(WIN_LEN);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         fill_q, fill_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] new_q, new_d;
    logic                  old_sel_q, old_sel_d;
    logic                  accept;

    assign accept = bus.din_valid & ~bus.clear;

    // Memory port: one shared pointer addresses both the write and the read.
    // Reset suppresses any access.
    assign bus.bram_wen  = accept & rst_n;
    assign bus.bram_ren  = accept & rst_n;
    assign bus.bram_wadd = ptr_q;
    assign bus.bram_radd = ptr_q;
    assign bus.bram_win  = bus.din;

    // Outputs: the departing sample is only meaningful for samples accepted in RUN.
    // Otherwise stale memory contents are masked to zero.
    assign bus.dout_valid = valid_q;
    assign bus.dout_new   = new_q;
    assign bus.dout_old   = (valid_q && old_sel_q) ? bus.bram_wout : '0;
    assign bus.full       = (state_q == RUN);
    assign bus.fill_cnt   = fill_q;

    // Next-state logic: clear flushes the window and overrides any sample presented with it.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        fill_d    = fill_q;
        valid_d   = 1'b0;
        new_d     = new_q;
        old_sel_d = old_sel_q;

        if (bus.clear) begin
            state_d = FILL;
            ptr_d   = '0;
            fill_d  = '0;
        end else if (bus.din_valid) begin
            ptr_d     = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);
            valid_d   = 1'b1;
            new_d     = bus.din;
            old_sel_d = (state_q == RUN);
            case (state_q)
                FILL: begin
                    fill_d = fill_q + CW'(1);
                    if (fill_q == FILL_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    fill_d = FILL_MAX;
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // State registers: asynchronous reset aborts any window in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            ptr_q     <= '0;
            fill_q    <= '0;
            valid_q   <= 1'b0;
            new_q     <= '0;
            old_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            fill_q    <= fill_d;
            valid_q   <= valid_d;
            new_q     <= new_d;
            old_sel_q <= old_sel_d;
        end
    end
endmodule

// File: tb/tb_moving_window_ctrl.sv
// Testbench for moving_window_ctrl. Two instances, with window lengths 4 and 5,
// share one stimulus stream. Each instance has its own read-first memory model.
// The expected values for both come from one history of the samples accepted
// since the last flush.
module tb_moving_window_ctrl;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] hist[$];
    logic          expValid = 1'b0;

    moving_window_ctrl_if #(.WIN_LEN(4), .DATA_WIDTH(DW)) if4 ();
    moving_window_ctrl_if #(.WIN_LEN(5), .DATA_WIDTH(DW)) if5 ();

    assign if4.clear = clear;
    assign if4.din = din;
    assign if4.din_valid = din_valid;
    assign if5.clear = clear;
    assign if5.din = din;
    assign if5.din_valid = din_valid;

    moving_window_ctrl #(.WIN_LEN(4), .DATA_WIDTH(DW)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    moving_window_ctrl #(.WIN_LEN(5), .DATA_WIDTH(DW)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));

    always #5 clk = ~clk;

    // Memory models: a registered read that sees the old contents on a same-address write.
    // Both memories start with random junk, so that stale data would show if it were not masked.
    logic [DW-1:0] mem4 [4];
    logic [DW-1:0] mem5 [5];
    logic          memReady = 1'b0;
    always @(posedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < 4; i++) mem4[i] <= DW'($urandom);
            for (int i = 0; i < 5; i++) mem5[i] <= DW'($urandom);
            memReady <= 1'b1;
        end else begin
            if (if4.bram_ren) if4.bram_wout <= mem4[if4.bram_radd];
            if (if4.bram_wen) mem4[if4.bram_wadd] <= if4.bram_win;
            if (if5.bram_ren) if5.bram_wout <= mem5[if5.bram_radd];
            if (if5.bram_wen) mem5[if5.bram_wadd] <= if5.bram_win;
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Memory-port view for a window of length L, checked while the inputs are stable.
    task automatic checkPort(input string p, input int L, input logic wen, input logic ren,
                             input logic [31:0] wadd, input logic [31:0] radd, input logic [DW-1:0] win);
        logic expWen;
        int   expAddr;
        expWen  = din_valid & ~clear & rst_n;
        expAddr = hist.size() % L;
        check({p, ".wen"}, 32'(wen), 32'(expWen));
        check({p, ".ren"}, 32'(ren), 32'(expWen));
        check({p, ".wadd"}, wadd, 32'(expAddr));
        check({p, ".radd"}, radd, 32'(expAddr));
        if (expWen) check({p, ".win"}, 32'(win), 32'(din));
    endtask

    // Window outputs for length L after the edge, derived from the accepted-sample history.
    task automatic checkDut(input string p, input int L, input logic v, input logic [DW-1:0] nw,
                            input logic [DW-1:0] od, input logic [31:0] fc, input logic fl);
        int n;
        n = hist.size();
        check({p, ".valid"}, 32'(v), 32'(expValid));
        check({p, ".fill"}, fc, 32'((n < L) ? n : L));
        check({p, ".full"}, 32'(fl), 32'(n >= L));
        if (expValid) begin
            check({p, ".new"}, 32'(nw), 32'(hist[n-1]));
            check({p, ".old"}, 32'(od), (n > L) ? 32'(hist[n-1-L]) : 32'd0);
        end
    endtask

    task automatic checkOutput();
        checkDut("d4", 4, if4.dout_valid, if4.dout_new, if4.dout_old, 32'(if4.fill_cnt), if4.full);
        checkDut("d5", 5, if5.dout_valid, if5.dout_new, if5.dout_old, 32'(if5.fill_cnt), if5.full);
    endtask

    // While reset is held, every output must be zero, even with a sample presented.
    task automatic checkResetState(input string p, input logic v, input logic [DW-1:0] nw,
                                   input logic [DW-1:0] od, input logic [31:0] fc,
                                   input logic fl, input logic wen);
        check({p, ".rst_valid"}, 32'(v), 32'd0);
        check({p, ".rst_new"}, 32'(nw), 32'd0);
        check({p, ".rst_old"}, 32'(od), 32'd0);
        check({p, ".rst_fill"}, fc, 32'd0);
        check({p, ".rst_full"}, 32'(fl), 32'd0);
        check({p, ".rst_wen"}, 32'(wen), 32'd0);
    endtask

    task automatic checkReset();
        checkResetState("d4", if4.dout_valid, if4.dout_new, if4.dout_old, 32'(if4.fill_cnt), if4.full, if4.bram_wen);
        checkResetState("d5", if5.dout_valid, if5.dout_new, if5.dout_old, 32'(if5.fill_cnt), if5.full, if5.bram_wen);
    endtask

    // One cycle: drive the inputs after the falling edge, check the memory port,
    // advance the model, cross the rising edge, then check the outputs.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic c);
        din_valid = v;
        din = d;
        clear = c;
        #1;
        checkPort("d4", 4, if4.bram_wen, if4.bram_ren, 32'(if4.bram_wadd), 32'(if4.bram_radd), if4.bram_win);
        checkPort("d5", 5, if5.bram_wen, if5.bram_ren, 32'(if5.bram_wadd), 32'(if5.bram_radd), if5.bram_win);
        if (c) begin
            hist.delete();
            expValid = 1'b0;
        end else if (v) begin
            hist.push_back(d);
            expValid = 1'b1;
        end else begin
            expValid = 1'b0;
        end
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        // Power-up reset with a sample presented: nothing may be written or emitted.
        din_valid = 1'b1;
        din = 16'hABCD;
        repeat (2) @(negedge clk);
        checkReset();
        rst_n = 1'b1;
        din_valid = 1'b0;
        hist.delete();
        expValid = 1'b0;
        $display("[TB] reset released");

        // Samples 1..6 back to back.
        for (int k = 1; k <= 6; k++) applyStimulus(1'b1, DW'(k), 1'b0);

        // Flush, then ten samples with an idle cycle after each.
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, DW'(k), 1'b0);
            applyStimulus(1'b0, DW'(16'h5555), 1'b0);
        end

        // Flush, then twelve samples so that both pointers wrap.
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 1; k <= 12; k++) applyStimulus(1'b1, DW'(k + 100), 1'b0);

        // Six samples, clear together with sample 7 (dropped), then samples 8 and 9.
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 1; k <= 6; k++) applyStimulus(1'b1, DW'(k), 1'b0);
        applyStimulus(1'b1, DW'(7), 1'b1);
        applyStimulus(1'b1, DW'(8), 1'b0);
        applyStimulus(1'b1, DW'(9), 1'b0);

        // A sample accepted just before a clear still produces its output.
        applyStimulus(1'b1, DW'(16'h0BEE), 1'b0);
        applyStimulus(1'b0, '0, 1'b1);

        // Random traffic with occasional flushes.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                          DW'($urandom),
                          ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        // Fill both windows into RUN, then pulse reset in the middle of a cycle.
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 1; k <= 8; k++) applyStimulus(1'b1, DW'(k + 200), 1'b0);
        check("d4.pre_rst_full", 32'(if4.full), 32'd1);
        check("d5.pre_rst_full", 32'(if5.full), 32'd1);
        din_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        din_valid = 1'b1;
        #1;
        checkReset();
        @(negedge clk);
        checkReset();
        rst_n = 1'b1;
        din_valid = 1'b0;
        hist.delete();
        expValid = 1'b0;
        $display("[TB] mid-stream reset released");
        for (int k = 1; k <= 7; k++) applyStimulus(1'b1, DW'(k + 300), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
